// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, rotate-unit FSM states and the
// default coarse step used by the iterative rotate-right unit.
package alu_pkg;

  localparam int ALU_WIDTH  = 32;
  localparam int ALU_AMT_W  = 5;
  localparam int ROR_COARSE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } ror_state_t;

endpackage

// File: rtl/ror_step.sv
// Single rotate-right step: by COARSE bits when sel_coarse, else by 1 bit.
// Purely combinational; no latency, no flow control.
module ror_step #(
  parameter int WIDTH  = 32,
  parameter int COARSE = 4
) (
  input  logic [WIDTH-1:0] data,
  input  logic             sel_coarse,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] ror_coarse;
  logic [WIDTH-1:0] ror_fine;

  assign ror_coarse = {data[COARSE-1:0], data[WIDTH-1:COARSE]};
  assign ror_fine   = {data[0], data[WIDTH-1:1]};
  assign data_out   = sel_coarse ? ror_coarse : ror_fine;

endmodule

// File: rtl/alu_ror_iter.sv
// Iterative rotate-right: COARSE bits/cycle then 1 bit/cycle; latency 1 (n=0) or S+1 cycles.
// Accepts only in IDLE; result held in DONE until out_ready, giving a 1-cycle bubble between ops.
module alu_ror_iter
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int AMT_W  = ALU_AMT_W,
  parameter int COARSE = ROR_COARSE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [AMT_W-1:0] numRotateBits,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [AMT_W-1:0] COARSE_AMT = AMT_W'(COARSE);
  localparam logic [AMT_W-1:0] ONE_AMT    = AMT_W'(1);

  ror_state_t       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;

  logic             sel_coarse;
  logic [WIDTH-1:0] step_dat;
  logic [AMT_W-1:0] cnt_dec;

  // cnt never underflows: a coarse step is only taken when cnt >= COARSE
  assign sel_coarse = (cnt_q >= COARSE_AMT);
  assign cnt_dec    = cnt_q - (sel_coarse ? COARSE_AMT : ONE_AMT);

  ror_step #(
    .WIDTH (WIDTH),
    .COARSE(COARSE)
  ) u_step (
    .data      (data_q),
    .sel_coarse(sel_coarse),
    .data_out  (step_dat)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = in;
          cnt_d  = numRotateBits;
          if (numRotateBits == '0) begin
            state_d = DONE;
            out_d   = in;
          end else begin
            state_d = ROT;
          end
        end
      end
      ROT: begin
        data_d = step_dat;
        cnt_d  = cnt_dec;
        // Final step loads the result register on the same edge
        if (cnt_dec == '0) begin
          state_d = DONE;
          out_d   = step_dat;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out       = out_q;

endmodule

// File: doc/alu_ror_iter.md
Name: alu_ror_iter

Overview:
- Iterative, multi-cycle rotate-right unit for the Mini SRC ALU; the counterpart of the single-cycle combinational rotate-left path.
- Accepts an operand and a 5-bit rotate amount over a valid/ready handshake.
- Rotates right by COARSE bits per cycle while at least COARSE bits remain, then by 1 bit per cycle.
- Presents the result on a held valid/ready output port; used where ROR is scheduled as a multi-cycle ALU op and area matters more than latency.

Parameters:
WIDTH, 32, operand and result width.
AMT_W, 5, rotate-amount width; must equal log2(WIDTH).
COARSE, 4, coarse step size in bits; must be a power of two and less than WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand and amount are valid.
in_ready  output  1  unit can accept an operand; high only in IDLE.
in  input  WIDTH  operand to rotate.
numRotateBits  input  AMT_W  rotate-right amount, 0..WIDTH-1.
out  output  WIDTH  rotated result; registered.
out_valid  output  1  result valid; high only in DONE.
out_ready  input  1  consumer accepts the result.
busy  output  1  high in ROT or DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; data=0, cnt=0, out=0, out_valid=0, busy=0, in_ready=1 once reset releases.
- FSM states: IDLE, ROT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge k: data<=in, cnt<=numRotateBits.
  - If numRotateBits==0, go to DONE; otherwise go to ROT.
- ROT, each edge:
  - If cnt>=COARSE: data<=ror(data,COARSE), cnt<=cnt-COARSE.
  - Else: data<=ror(data,1), cnt<=cnt-1.
  - When the new cnt==0, go to DONE and load out with the rotated value in the same edge.
- DONE:
  - out_valid=1; out and out_valid are held stable until out_ready=1.
  - On out_valid&&out_ready: go to IDLE and drop out_valid. out keeps its last value; it is not cleared.
- Step count S = floor(n/COARSE) + (n mod COARSE).
- Latency, accept edge to first cycle with out_valid=1: 1 cycle for n=0, S+1 cycles for n>0. Worst case with defaults is n=31, S=10, latency 11.
- Width rules: rotation is modulo WIDTH with no bits lost; ror(x,k) = {x[k-1:0], x[WIDTH-1:k]}. cnt is AMT_W bits and never underflows.
- in_valid while busy: ignored; in_ready=0, and the input is not latched.
- Back-to-back: in_ready is low in DONE, so the earliest next accept is the cycle after the output handshake, giving a 1-cycle bubble.
- Reset mid-operation (ROT or DONE): immediate return to IDLE. out_valid=0 and out=0 asynchronously; the pending result is discarded.
- numRotateBits changing after accept has no effect.

Decomposition:
- Shared package alu_pkg:
  - WIDTH and AMT_W constants.
  - ror_state_t enum {IDLE, ROT, DONE}.
  - COARSE default.
- Sub-module ror_step: combinational; inputs data and sel_coarse; outputs data rotated right by COARSE or by 1.
- Top level contains the FSM, the cnt counter and the data/out registers.

Test Plan:
- in=0x80000001, n=1 -> out=0xC0000000; out_valid 2 cycles after accept.
- in=0x12345678, n=8 -> out=0x78123456; S=2, out_valid 3 cycles after accept.
- in=0xDEADBEEF, n=0 -> out=0xDEADBEEF; out_valid 1 cycle after accept, no ROT cycles.
- in=0x00000001, n=31 -> out=0x00000002; out_valid 11 cycles after accept. Also in=0xF0000000, n=5 -> 0x07800000 (mixed coarse and fine steps).
- Back-pressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and a new operand present -> out and out_valid stable, in_ready=0, new operand not latched. Release out_ready -> IDLE next cycle, then the new operand is accepted.
- Reset: assert rst_n=0 in ROT during an n=31 operation -> out_valid=0, out=0, busy=0 without waiting for a clock. After release, in=0xA5A5A5A5, n=4 -> 0x5A5A5A5A.
